pwm_multi: RTL and testbench
============================

# pwm_multi

Multi-channel, parametrised PWM generator for the audio path. It is the successor of the single-channel 24-bit PWM that drives the analog reconstruction filter. Each channel compares a shared free-running counter against its own duty register. Period, duty and counting mode are double-buffered and only take effect at a period boundary, so outputs never glitch mid-period. It supports edge-aligned and center-aligned modes and per-channel polarity, and it sits between the Wishbone register slice and the output pins.

## Interface
- WIDTH, 16, counter/period/duty width in bits (2..32)
- CHANNELS, 2, number of PWM outputs (1..8)
- PERIOD_DEFAULT, 12000, period value loaded at reset
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  chip select / run; low = counter held, outputs inactive
- load  in  1  one-cycle strobe; captures period, mode, duty into shadow registers
- period  in  WIDTH  period value P
- mode  in  1  0 = edge-aligned, 1 = center-aligned
- duty  in  CHANNELS*WIDTH  channel i duty D[i] in bits [i*WIDTH +: WIDTH]
- invert  in  CHANNELS  per-channel output polarity, applied live (not buffered)
- pwmout  out  CHANNELS  registered PWM outputs
- cycle_start  out  1  one-cycle pulse at each period boundary
- status  out  8  {pwmout[3:0] zero-padded, mode_a, pending, dir, enable}

## Operation
- Registers:
  - shadow set: P_s, mode_s, D_s[i]
  - active set: P_a, mode_a, D_a[i]
  - pending flag, counter cnt (WIDTH bits), direction flag dir (0 = up)
- load = 1 → shadow set <= inputs; pending <= 1. Inputs are ignored when load = 0.
- Edge mode (mode_a = 0):
  - cnt sequence 0, 1, …, P_a, 0, …; period = P_a+1 cycles.
  - Boundary = cycle with cnt == P_a. P_a = 0 → cnt stays 0 and every cycle is a boundary.
- Center mode (mode_a = 1):
  - cnt counts up 0 → P_a−1, repeats P_a−1 with dir flipped to down, then counts down to 0, repeats 0 with dir flipped to up; period = 2·P_a cycles.
  - Boundary = cycle with cnt == 0 and dir == down. P_a = 0 is treated as P_a = 1.
- Compare: pwmout[i] <= (cnt < D_a[i]) XOR invert[i].
  - Unsigned compare, full WIDTH.
  - D = 0 → constantly inactive.
  - D > P_a (edge) or D ≥ P_a (center) → constantly active.
- At a boundary with enable = 1:
  - If pending = 1: active set <= shadow set, pending <= 0.
  - cnt <= 0, dir <= up.
  - cycle_start <= 1; otherwise cycle_start <= 0.
- load on a boundary cycle: shadow takes the new values and pending stays 1. The new values apply at the next boundary. The old shadow contents were already transferred only if pending was set before that cycle.
- enable = 0:
  - cnt <= 0, dir <= up, cycle_start <= 0, pwmout[i] <= invert[i].
  - If pending: active set <= shadow set immediately, pending <= 0.
  - load still captures into shadow.
- High cycles per period:
  - edge: min(D, P_a+1)
  - center: 2·min(D, P_a)
- status is registered alongside pwmout: bit0 enable, bit1 dir, bit2 pending, bit3 mode_a, bits[4+k] = pwmout[k] for k < min(4, CHANNELS), remaining bits 0.

## Timing
- Reset values:
  - cnt = 0, dir = up, pending = 0
  - P_s = P_a = PERIOD_DEFAULT, mode_s = mode_a = 0, all D_s = D_a = 0
  - pwmout = 0, cycle_start = 0, status = 0
- Reset overrides load and enable, and aborts any period in progress.
- Output latency: pwmout reflects cnt one cycle earlier (single register stage). invert takes effect on the next clock.
- enable 0 → 1: first active-phase cnt = 0 on the first enabled cycle. pwmout first reflects it one cycle later.
- Transfer latency: load at cycle t with no boundary → new values apply from the first cycle after the next boundary.
- cycle_start is asserted during the cycle with cnt = 0 immediately after each boundary.

## Test plan
- Reset, enable = 1, load P = 9, mode 0, D0 = 3, D1 = 10 → ch0 high 3 of every 10 cycles, ch1 constantly high, cycle_start every 10 cycles.
- Center mode, P = 4, D0 = 2 → cnt 0,1,2,3,3,2,1,0; ch0 high 4 of 8 cycles, symmetric around cnt = 3; dir flips at 3 and 0.
- Mid-period load changing D0 3 → 7 (P = 9) → current period keeps 3 high cycles, next period 7; no runt pulse; pending = 1 until the boundary.
- load coincident with boundary → values apply one period later; status bit2 stays 1 across that boundary.
- enable dropped at cnt = 5 with invert = 2'b10 → pwmout = 2'b10 next cycle, cnt = 0; re-enable → counting restarts at 0 with the shadow values applied.
- reset asserted mid-period with pending = 1 → all outputs 0, P_a = 12000, pending = 0 on the next cycle.

Source files
------------

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: a shared counter compared against per-channel
// duty values, with double-buffered period/mode/duty that switch only at a
// period boundary (or immediately while disabled).
module pwm_multi #(
    parameter int          WIDTH          = 16,
    parameter int          CHANNELS       = 2,
    parameter int unsigned PERIOD_DEFAULT = 12000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      load,
    input  logic [WIDTH-1:0]          period,
    input  logic                      mode,
    input  logic [CHANNELS*WIDTH-1:0] duty,
    input  logic [CHANNELS-1:0]       invert,
    output logic [CHANNELS-1:0]       pwmout,
    output logic                      cycle_start,
    output logic [7:0]                status
);

    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
    localparam int               STATUS_CH = (CHANNELS < 4) ? CHANNELS : 4;

    // Shadow set (written by load) and active set (used by the compare).
    logic [WIDTH-1:0]          period_s, period_a;
    logic                      mode_s, mode_a;
    logic [CHANNELS*WIDTH-1:0] duty_s, duty_a;
    logic                      pending;

    logic [WIDTH-1:0]          cnt, cnt_next;
    logic                      dir, dir_next;      // 0 = counting up
    logic [WIDTH-1:0]          period_eff;
    logic                      boundary;
    logic                      transfer;
    logic [CHANNELS-1:0]       pwm_next;
    logic [7:0]                status_next;

    // Center mode treats a zero period as one so the counter still turns around.
    assign period_eff = (period_a == '0) ? ONE : period_a;
    assign boundary   = mode_a ? ((cnt == '0) && dir) : (cnt == period_a);
    assign transfer   = pending && (!enable || boundary);

    // Next counter value and direction for edge/center counting.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        cnt_next = cnt;
        dir_next = dir;
        if (!enable || boundary) begin
            cnt_next = '0;
            dir_next = 1'b0;
        end else if (!mode_a) begin
            cnt_next = cnt + ONE;
        end else if (!dir) begin
            // The top value is held for a second cycle while the direction flips.
            if (cnt == period_eff - ONE) begin
                dir_next = 1'b1;
            end else begin
                cnt_next = cnt + ONE;
            end
        end else begin
            cnt_next = cnt - ONE;
        end
    end

    // Per-channel compare; disabled channels sit at their inactive level.
    always_comb begin
        pwm_next = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            pwm_next[i] = (enable && (cnt < duty_a[i*WIDTH +: WIDTH])) ^ invert[i];
        end
    end

    // Status word captured in the same stage as pwmout.
    always_comb begin
        status_next    = '0;
        status_next[0] = enable;
        status_next[1] = dir;
        status_next[2] = pending;
        status_next[3] = mode_a;
        for (int k = 0; k < STATUS_CH; k++) begin
            status_next[4+k] = pwm_next[k];
        end
    end

    // Shadow capture, shadow-to-active transfer and the pending flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the configuration registers are explicitly reset because the counter and compare depend on them from the first enabled cycle.
            period_s <= WIDTH'(PERIOD_DEFAULT);
            period_a <= WIDTH'(PERIOD_DEFAULT);
            mode_s   <= 1'b0;
            mode_a   <= 1'b0;
            duty_s   <= '0;
            duty_a   <= '0;
            pending  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make the transfer read the shadow values from before this cycle's load.
            if (load) begin
                period_s <= period;
                mode_s   <= mode;
                duty_s   <= duty;
            end
            if (transfer) begin
                period_a <= period_s;
                mode_a   <= mode_s;
                duty_a   <= duty_s;
            end
            if (load) begin
                pending <= 1'b1;
            end else if (transfer) begin
                pending <= 1'b0;
            end
        end
    end

    // Counter, direction and the registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            dir         <= 1'b0;
            pwmout      <= '0;
            cycle_start <= 1'b0;
            status      <= '0;
        end else begin
            cnt         <= cnt_next;
            dir         <= dir_next;
            pwmout      <= pwm_next;
            cycle_start <= enable && boundary;
            status      <= status_next;
        end
    end

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi: each stimulus phase pushes the expected
// per-cycle outputs into a scoreboard that is drained on the falling edge.
module tb_pwm_multi;

    localparam int WIDTH    = 16;
    localparam int CHANNELS = 2;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      enable;
    logic                      load;
    logic [WIDTH-1:0]          period;
    logic                      mode;
    logic [CHANNELS*WIDTH-1:0] duty;
    logic [CHANNELS-1:0]       invert;
    logic [CHANNELS-1:0]       pwmout;
    logic                      cycle_start;
    logic [7:0]                status;

    pwm_multi #(
        .WIDTH         (WIDTH),
        .CHANNELS      (CHANNELS),
        .PERIOD_DEFAULT(12000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .load       (load),
        .period     (period),
        .mode       (mode),
        .duty       (duty),
        .invert     (invert),
        .pwmout     (pwmout),
        .cycle_start(cycle_start),
        .status     (status)
    );

    always #5 clk = ~clk;

    // Cycle index: value k is visible between posedge k and posedge k+1.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        string      tag;
        logic [1:0] pwm;
        logic       cs;
        logic [7:0] st;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expected);
        checks++;
        if (got !== expected) begin
            errors++;
            $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, expected);
        end
    endtask

    // Expected outputs for cycle 'at'; status fields are the state one cycle earlier.
    task automatic push(input int at, input string tag, input logic [1:0] pwm, input logic cs,
                        input logic mode_a, input logic pend, input logic dir, input logic en);
        exp_t e;
        e.at  = at;
        e.tag = tag;
        e.pwm = pwm;
        e.cs  = cs;
        e.st  = {2'b00, pwm, mode_a, pend, dir, en};
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_cfg(input logic [15:0] p, input logic m, input logic [15:0] d0, input logic [15:0] d1);
        period = p;
        mode   = m;
        duty   = {d1, d0};
        load   = 1'b1;
    endtask

    // Scoreboard drain, away from the active edge.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            mon_e = sb.pop_front();
            if (mon_e.at < cyc) begin
                check({mon_e.tag, "_missed"}, mon_e.at, cyc);
            end else begin
                check({mon_e.tag, "_pwm"},    pwmout,      mon_e.pwm);
                check({mon_e.tag, "_cs"},     cycle_start, mon_e.cs);
                check({mon_e.tag, "_status"}, status,      mon_e.st);
            end
        end
    end

    initial begin
        int b;
        int b7;
        int b5;
        int c;
        int d;
        int j;

        reset  = 1'b1;
        enable = 1'b0;
        load   = 1'b0;
        period = '0;
        mode   = 1'b0;
        duty   = '0;
        invert = '0;

        // Reset state.
        step(1);
        push(2, "reset", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(3, "reset", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(2);

        // Default period 12000: boundary after 12001 cycles, duty 0 stays low.
        b      = cyc;
        reset  = 1'b0;
        enable = 1'b1;
        for (int k = b + 1; k <= b + 12002; k++)
            push(k, "default", 2'b00, k == b + 12001, 1'b0, 1'b0, 1'b0, 1'b1);
        step(12002);

        // Load while disabled: transfer happens immediately on the next disabled cycle.
        b      = cyc;
        enable = 1'b0;
        set_cfg(9, 1'b0, 3, 10);
        push(b + 1, "load_dis", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(b + 2, "load_dis", 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1);
        load = 1'b0;
        step(1);

        // Edge mode P=9, D0=3, D1=10.
        b      = cyc;
        enable = 1'b1;
        for (int k = b + 1; k <= b + 20; k++) begin
            c = (k - 1 - b) % 10;
            push(k, "edge", {1'b1, c < 3}, (k - b) % 10 == 0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        step(20);

        // Mid-period load D0 3 -> 7 at cnt = 4.
        b = cyc;
        for (int k = b + 1; k <= b + 20; k++) begin
            c = (k - 1 - b) % 10;
            d = (k - 1 < b + 10) ? 3 : 7;
            push(k, "midload", {1'b1, c < d}, (k - b) % 10 == 0, 1'b0,
                 (k - 1 >= b + 5) && (k - 1 <= b + 9), 1'b0, 1'b1);
        end
        step(4);
        set_cfg(9, 1'b0, 7, 10);
        step(1);
        load = 1'b0;
        step(15);

        // Load D0=2 mid-period, then load D0=5 exactly on the boundary.
        b = cyc;
        for (int k = b + 1; k <= b + 30; k++) begin
            c = (k - 1 - b) % 10;
            j = (k - 1 - b) / 10;
            d = (j == 0) ? 7 : ((j == 1) ? 2 : 5);
            push(k, "bndload", {1'b1, c < d}, (k - b) % 10 == 0, 1'b0,
                 (k - 1 >= b + 7) && (k - 1 <= b + 19), 1'b0, 1'b1);
        end
        step(6);
        set_cfg(9, 1'b0, 2, 10);
        step(1);
        load = 1'b0;
        step(2);
        set_cfg(9, 1'b0, 5, 10);
        step(1);
        load = 1'b0;
        step(20);

        // Drop enable at cnt = 5 with invert = 2'b10, pending shadow D0=4.
        b = cyc;
        for (int k = b + 1; k <= b + 5; k++)
            push(k, "pre_dis", 2'b11, 1'b0, 1'b0, k - 1 >= b + 2, 1'b0, 1'b1);
        push(b + 6, "disable", 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        push(b + 7, "disable", 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        b7 = b + 7;
        for (int k = b7 + 1; k <= b7 + 10; k++) begin
            c = (k - 1 - b7) % 10;
            push(k, "reenable", {1'b0, c < 4}, k == b7 + 10, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        step(1);
        set_cfg(9, 1'b0, 4, 10);
        step(1);
        load = 1'b0;
        step(3);
        enable = 1'b0;
        invert = 2'b10;
        step(2);
        enable = 1'b1;
        step(10);

        // Center mode P=4, D0=2, D1=4 loaded at the start of a period.
        b      = cyc;
        invert = 2'b00;
        set_cfg(4, 1'b1, 2, 4);
        for (int k = b + 1; k <= b + 10; k++) begin
            c = k - 1 - b;
            push(k, "pre_ctr", {1'b1, c < 4}, k == b + 10, 1'b0, k - 1 >= b + 1, 1'b0, 1'b1);
        end
        b5 = b + 10;
        for (int k = b5 + 1; k <= b5 + 16; k++) begin
            j = (k - 1 - b5) % 8;
            c = (j < 4) ? j : 7 - j;
            push(k, "center", {1'b1, c < 2}, (k - b5) % 8 == 0, 1'b1, 1'b0, j >= 4, 1'b1);
        end
        step(1);
        load = 1'b0;
        step(25);

        // Reset mid-period with a pending load; enable held high through reset.
        b = cyc;
        step(1);
        set_cfg(9, 1'b0, 1, 1);
        step(1);
        load = 1'b0;
        step(1);
        reset = 1'b1;
        push(b + 4, "reset_mid", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1);
        b     = cyc;
        reset = 1'b0;
        for (int k = b + 1; k <= b + 40; k++)
            push(k, "post_reset", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(42);

        check("scoreboard_drain", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
